mcu_frame_parser: RTL and testbench

- Receive-side front end of the MCU↔FPGA UART command link.
- Consumes bytes from the UART receiver and hunts for a command frame: start code, ctrl code, len_lo, len_hi, payload, checksum, end code.
- Validates each frame and presents the ctrl code plus the 32-bit parameter to the command consumers (parameter setting, query handlers) over a valid/ready handshake.
- Reports malformed frames with an error code so the reply path can NAK them.

---
 rtl/mcu_frame_parser_pkg.sv | 40 ++++
 rtl/mcu_frame_parser_rx_byte_edge.sv | 26 ++
 rtl/mcu_frame_parser.sv | 219 +++++++++++++++++++++
 tb/tb_mcu_frame_parser.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_frame_parser_pkg.sv
// Shared MCU link protocol header: frame codes, ctrl codes, error codes
// and the receive-parser state encoding.
package mcu_frame_parser_pkg;

    localparam logic [7:0] START_CODE = 8'h68;
    localparam logic [7:0] END_CODE   = 8'h16;
    localparam logic [7:0] ACK_OK     = 8'hFF;

    // Ctrl codes understood by the command consumers
    localparam logic [7:0] CTRL_SET_PARA  = 8'h21;
    localparam logic [7:0] CTRL_QUERY     = 8'h22;
    localparam logic [7:0] CTRL_QUERY_ST  = 8'h23;
    localparam logic [7:0] CTRL_RESET_CNT = 8'h24;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_LEN  = 3'd1,
        ERR_CRC  = 3'd2,
        ERR_END  = 3'd3,
        ERR_OVR  = 3'd4,
        ERR_TMO  = 3'd5
    } err_code_e;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CTRL    = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_LEN_HI  = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CRC     = 3'd5,
        ST_END     = 3'd6,
        ST_HOLD    = 3'd7
    } rx_state_e;

    // 8-bit wrap-around running checksum update
    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/mcu_frame_parser_rx_byte_edge.sv
// rx_byte_edge: two-flop synchronizer plus rising-edge detect.
// Both flops reset high so a level already high at reset is not an edge.
module rx_byte_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;

    // Synchronize the asynchronous level into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_level;
            r_sync2 <= r_sync1;
        end
    end

    assign o_rise = r_sync1 & ~r_sync2;

endmodule

// File: rtl/mcu_frame_parser.sv
// mcu_frame_parser: receive-side UART command frame parser.
// Frame: START ctrl len_lo len_hi payload[len_lo] crc END,
// crc = ~(ctrl + len_lo + len_hi + payload), 8-bit wrap.
// Optional build macro FRAME_TIMEOUT_EN adds an inter-byte idle timeout.
module mcu_frame_parser
    import mcu_frame_parser_pkg::*;
#(
    parameter int          MAX_PAYLOAD    = 4,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ok,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_ctrl,
    output logic [3:0]  cmd_len,
    output logic [31:0] cmd_para,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy
);

    rx_state_e   r_state;
    rx_state_e   w_next;

    logic        w_stb;
    logic        w_tmo;
    logic        w_accept;
    logic        w_err;
    err_code_e   w_err_code;
    logic        w_load;

    logic [7:0]  r_ctrl;
    logic [7:0]  r_len;
    logic [7:0]  r_sum;
    logic [31:0] r_para;
    logic [3:0]  r_idx;

    logic        r_cmd_valid;
    logic [7:0]  r_cmd_ctrl;
    logic [3:0]  r_cmd_len;
    logic [31:0] r_cmd_para;
    logic        r_frame_err;
    err_code_e   r_err_code;

    rx_byte_edge u_rx_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (rx_ok),
        .o_rise  (w_stb)
    );

    assign w_accept = r_cmd_valid & cmd_ready;

`ifdef FRAME_TIMEOUT_EN
    logic [19:0] r_tmo_cnt;
    logic        w_tmo_run;

    // Idle timer only runs while a frame is in flight
    assign w_tmo_run = (r_state != ST_HUNT) && (r_state != ST_HOLD);
    assign w_tmo     = w_tmo_run && !w_stb && (r_tmo_cnt == TIMEOUT_CYCLES - 20'd1);

    // Count idle cycles between bytes; any byte restarts the count
    always_ff @(posedge clk) begin
        if (rst || w_stb || !w_tmo_run || w_tmo)
            r_tmo_cnt <= 20'd0;
        else
            r_tmo_cnt <= r_tmo_cnt + 20'd1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_HUNT;
        else     r_state <= w_next;
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        w_load     = 1'b0;
        case (r_state)
            ST_HUNT:    if (w_stb && rx_data == START_CODE) w_next = ST_CTRL;
            ST_CTRL:    if (w_stb) w_next = ST_LEN_LO;
            ST_LEN_LO:  if (w_stb) w_next = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_stb) begin
                    if (rx_data != 8'd0 || r_len > 8'(MAX_PAYLOAD)) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_LEN;
                        w_next     = ST_HUNT;
                    end else if (r_len == 8'd0) begin
                        w_next = ST_CRC;
                    end else begin
                        w_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: if (w_stb && {4'd0, r_idx} == r_len - 8'd1) w_next = ST_CRC;
            ST_CRC: begin
                if (w_stb) begin
                    if (rx_data != ~r_sum) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CRC;
                        w_next     = ST_HUNT;
                    end else begin
                        w_next = ST_END;
                    end
                end
            end
            ST_END: begin
                if (w_stb) begin
                    if (rx_data != END_CODE) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_END;
                        w_next     = ST_HUNT;
                    end else begin
                        w_load = 1'b1;
                        w_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Held frame is never disturbed; an incoming byte is just lost
                if (w_stb) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVR;
                end
                if (w_accept) w_next = ST_HUNT;
            end
            default: w_next = ST_HUNT;
        endcase
        if (w_tmo) begin
            w_err      = 1'b1;
            w_err_code = ERR_TMO;
            w_next     = ST_HUNT;
        end
    end

    // Working frame registers: ctrl, length, running sum, payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= 8'd0;
            r_len  <= 8'd0;
            r_sum  <= 8'd0;
            r_para <= 32'd0;
            r_idx  <= 4'd0;
        end else if (w_stb) begin
            case (r_state)
                ST_HUNT: begin
                    // Clearing here lets short payloads zero-fill
                    if (rx_data == START_CODE) begin
                        r_para <= 32'd0;
                        r_idx  <= 4'd0;
                    end
                end
                ST_CTRL: begin
                    r_ctrl <= rx_data;
                    r_sum  <= rx_data;
                end
                ST_LEN_LO: begin
                    r_len <= rx_data;
                    r_sum <= sum_add(r_sum, rx_data);
                end
                ST_LEN_HI: r_sum <= sum_add(r_sum, rx_data);
                ST_PAYLOAD: begin
                    // Bytes beyond the 32-bit parameter still feed the checksum
                    if (r_idx < 4'd4) r_para[{r_idx[1:0], 3'b000} +: 8] <= rx_data;
                    r_idx <= r_idx + 4'd1;
                    r_sum <= sum_add(r_sum, rx_data);
                end
                default: ;
            endcase
        end
    end

    // Command output registers with valid/ready hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd_ctrl  <= 8'd0;
            r_cmd_len   <= 4'd0;
            r_cmd_para  <= 32'd0;
        end else if (w_load) begin
            r_cmd_valid <= 1'b1;
            r_cmd_ctrl  <= r_ctrl;
            r_cmd_len   <= r_len[3:0];
            r_cmd_para  <= r_para;
        end else if (w_accept) begin
            r_cmd_valid <= 1'b0;
        end
    end

    // Error pulse and sticky error code
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_frame_err <= w_err;
            if (w_err) r_err_code <= w_err_code;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_ctrl  = r_cmd_ctrl;
    assign cmd_len   = r_cmd_len;
    assign cmd_para  = r_cmd_para;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign busy      = (r_state != ST_HUNT);

endmodule

// File: tb/tb_mcu_frame_parser.sv
// Directed bench for mcu_frame_parser. Build with +define+FRAME_TIMEOUT_EN
// to exercise the idle timeout (TIMEOUT_CYCLES overridden to 100).
module tb_mcu_frame_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ok = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  cmd_ctrl;
    logic [3:0]  cmd_len;
    logic [31:0] cmd_para;
    logic        frame_err;
    logic [2:0]  err_code;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Event monitor results
    int          n_err;
    int          n_vcyc;
    int          n_vrise;
    int          n_coinc;
    logic        prev_v;
    logic [7:0]  cap_ctrl;
    logic [3:0]  cap_len;
    logic [31:0] cap_para;

    mcu_frame_parser #(
        .MAX_PAYLOAD    (4),
        .TIMEOUT_CYCLES (20'd100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ok     (rx_ok),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ctrl  (cmd_ctrl),
        .cmd_len   (cmd_len),
        .cmd_para  (cmd_para),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (frame_err) n_err = n_err + 1;
            if (cmd_valid) n_vcyc = n_vcyc + 1;
            if (cmd_valid && !prev_v) begin
                n_vrise  = n_vrise + 1;
                cap_ctrl = cmd_ctrl;
                cap_len  = cmd_len;
                cap_para = cmd_para;
                if (frame_err) n_coinc = n_coinc + 1;
            end
            prev_v <= cmd_valid;
        end
    end

    task automatic clr_mon();
        n_err = 0; n_vcyc = 0; n_vrise = 0;
        cap_ctrl = 8'd0; cap_len = 4'd0; cap_para = 32'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_ok   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] bytes[], input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[i]);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 7;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", cmd_valid); end
        if (cmd_ctrl !== 8'h00) begin failures++; $display("FAIL rst_ctrl got=%h exp=00", cmd_ctrl); end
        if (cmd_len !== 4'h0) begin failures++; $display("FAIL rst_len got=%h exp=0", cmd_len); end
        if (cmd_para !== 32'h0) begin failures++; $display("FAIL rst_para got=%h exp=0", cmd_para); end
        if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", frame_err); end
        if (err_code !== 3'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", err_code); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        logic [7:0] f[] = '{8'h68, 8'h21, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h30, 8'h16};
        clr_mon();
        cmd_ready = 1'b1;
        send_frame(f, 10);
        checks += 6;
        if (n_vcyc != 1) begin failures++; $display("FAIL good_vcyc got=%0d exp=1", n_vcyc); end
        if (cap_ctrl !== 8'h21) begin failures++; $display("FAIL good_ctrl got=%h exp=21", cap_ctrl); end
        if (cap_len !== 4'd4) begin failures++; $display("FAIL good_len got=%0d exp=4", cap_len); end
        if (cap_para !== 32'h44332211) begin failures++; $display("FAIL good_para got=%h exp=44332211", cap_para); end
        if (n_err != 0) begin failures++; $display("FAIL good_err got=%0d exp=0", n_err); end
        if (busy !== 1'b0) begin failures++; $display("FAIL good_busy got=%b exp=0", busy); end
    endtask

    task automatic test_garbage();
        // checksum = ~(21+01+00+7F) = ~A1 = 5E
        logic [7:0] f[] = '{8'h00, 8'h55, 8'h68, 8'h21, 8'h01, 8'h00, 8'h7F, 8'h5E, 8'h16};
        clr_mon();
        send_frame(f, 9);
        checks += 4;
        if (n_vrise != 1) begin failures++; $display("FAIL garb_vrise got=%0d exp=1", n_vrise); end
        if (cap_para !== 32'h0000007F) begin failures++; $display("FAIL garb_para got=%h exp=0000007f", cap_para); end
        if (cap_len !== 4'd1) begin failures++; $display("FAIL garb_len got=%0d exp=1", cap_len); end
        if (n_err != 0) begin failures++; $display("FAIL garb_err got=%0d exp=0", n_err); end
    endtask

    task automatic test_crc_end_err();
        logic [7:0] fc[] = '{8'h68, 8'h21, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h31, 8'h16};
        logic [7:0] fe[] = '{8'h68, 8'h21, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h30, 8'h17};
        clr_mon();
        send_frame(fc, 10);
        checks += 3;
        if (n_err != 1) begin failures++; $display("FAIL crc_npulse got=%0d exp=1", n_err); end
        if (err_code !== 3'd2) begin failures++; $display("FAIL crc_code got=%0d exp=2", err_code); end
        if (n_vrise != 0) begin failures++; $display("FAIL crc_valid got=%0d exp=0", n_vrise); end
        clr_mon();
        send_frame(fe, 10);
        checks += 4;
        if (n_err != 1) begin failures++; $display("FAIL end_npulse got=%0d exp=1", n_err); end
        if (err_code !== 3'd3) begin failures++; $display("FAIL end_code got=%0d exp=3", err_code); end
        if (n_vrise != 0) begin failures++; $display("FAIL end_valid got=%0d exp=0", n_vrise); end
        if (busy !== 1'b0) begin failures++; $display("FAIL end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_len_reject();
        logic [7:0] fh[] = '{8'h68, 8'h21, 8'h05, 8'h00};
        logic [7:0] ft[] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h30, 8'h16};
        clr_mon();
        send_frame(fh, 4);
        checks += 3;
        if (n_err != 1) begin failures++; $display("FAIL len_npulse got=%0d exp=1", n_err); end
        if (err_code !== 3'd1) begin failures++; $display("FAIL len_code got=%0d exp=1", err_code); end
        if (busy !== 1'b0) begin failures++; $display("FAIL len_busy got=%b exp=0", busy); end
        send_frame(ft, 7);
        checks += 3;
        if (n_err != 1) begin failures++; $display("FAIL len_tail_err got=%0d exp=1", n_err); end
        if (n_vrise != 0) begin failures++; $display("FAIL len_tail_valid got=%0d exp=0", n_vrise); end
        if (busy !== 1'b0) begin failures++; $display("FAIL len_tail_busy got=%b exp=0", busy); end
    endtask

    task automatic test_overrun();
        // checksum = ~(22+02+00+AA+55) = ~23 = DC
        logic [7:0] f[] = '{8'h68, 8'h22, 8'h02, 8'h00, 8'hAA, 8'h55, 8'hDC, 8'h16};
        clr_mon();
        cmd_ready = 1'b0;
        send_frame(f, 8);
        checks += 4;
        if (cmd_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", cmd_valid); end
        if (cmd_para !== 32'h000055AA) begin failures++; $display("FAIL hold_para got=%h exp=000055aa", cmd_para); end
        if (cmd_len !== 4'd2) begin failures++; $display("FAIL hold_len got=%0d exp=2", cmd_len); end
        if (n_err != 0) begin failures++; $display("FAIL hold_err got=%0d exp=0", n_err); end
        send_byte(8'h68);
        repeat (2) @(posedge clk); #1;
        checks += 5;
        if (n_err != 1) begin failures++; $display("FAIL ovr_npulse got=%0d exp=1", n_err); end
        if (err_code !== 3'd4) begin failures++; $display("FAIL ovr_code got=%0d exp=4", err_code); end
        if (cmd_para !== 32'h000055AA) begin failures++; $display("FAIL ovr_para got=%h exp=000055aa", cmd_para); end
        if (cmd_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", cmd_valid); end
        if (busy !== 1'b1) begin failures++; $display("FAIL ovr_busy got=%b exp=1", busy); end
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks += 3;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rel_valid got=%b exp=0", cmd_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rel_busy got=%b exp=0", busy); end
        if (n_coinc != 0) begin failures++; $display("FAIL err_on_vrise got=%0d exp=0", n_coinc); end
    endtask

    task automatic test_timeout();
        logic [7:0] f[] = '{8'h68, 8'h21};
        clr_mon();
        send_frame(f, 2);
        repeat (150) @(posedge clk); #1;
`ifdef FRAME_TIMEOUT_EN
        checks += 3;
        if (n_err != 1) begin failures++; $display("FAIL tmo_npulse got=%0d exp=1", n_err); end
        if (err_code !== 3'd5) begin failures++; $display("FAIL tmo_code got=%0d exp=5", err_code); end
        if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy); end
`else
        checks += 2;
        if (n_err != 0) begin failures++; $display("FAIL stall_err got=%0d exp=0", n_err); end
        if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] fh[] = '{8'h68, 8'h21, 8'h04, 8'h00, 8'h11};
        logic [7:0] fg[] = '{8'h68, 8'h21, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h30, 8'h16};
        // First get a held value into cmd_para so the reset has something to clear
        rst = 1'b1; repeat (2) @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        cmd_ready = 1'b0;
        send_frame(fg, 10);
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        clr_mon();
        send_frame(fh, 5);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", cmd_valid); end
        if (cmd_ctrl !== 8'h00) begin failures++; $display("FAIL mid_ctrl got=%h exp=00", cmd_ctrl); end
        if (cmd_para !== 32'h0) begin failures++; $display("FAIL mid_para got=%h exp=0", cmd_para); end
        if (cmd_len !== 4'h0) begin failures++; $display("FAIL mid_len got=%h exp=0", cmd_len); end
        if (err_code !== 3'd0) begin failures++; $display("FAIL mid_code got=%0d exp=0", err_code); end
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        clr_mon();
        send_frame(fg, 10);
        checks += 3;
        if (n_err != 0) begin failures++; $display("FAIL post_err got=%0d exp=0", n_err); end
        if (n_vrise != 1) begin failures++; $display("FAIL post_vrise got=%0d exp=1", n_vrise); end
        if (cap_para !== 32'h44332211) begin failures++; $display("FAIL post_para got=%h exp=44332211", cap_para); end
    endtask

    initial begin
        n_coinc = 0;
        clr_mon();
        test_reset();
        test_good_frame();
        test_garbage();
        test_crc_end_err();
        test_len_reject();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
